mips_ctrl_fsm: RTL and testbench

//  Multi-cycle MIPS control unit: the producer side of the ALU interface. Accepts one

---
 rtl/mips_ctrl_fsm_if.sv | 38 +++
 rtl/mips_ctrl_fsm.sv | 182 ++++++++++++++++++
 tb/tb_mips_ctrl_fsm.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_ctrl_fsm_if.sv
// Control-unit bus: fetch handshake, register-file addressing, ALU controls,
// data-memory request and PC-update strobes. The controller is the master side.
interface mips_ctrl_fsm_if;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [4:0]  rf_raddr1;
  logic [4:0]  rf_raddr2;
  logic [1:0]  alu_op;
  logic        alu_src;
  logic [5:0]  alu_funct;
  logic [4:0]  alu_shamt;
  logic [31:0] alu_immd;
  logic        alu_zero;
  logic        mem_req;
  logic        mem_we;
  logic        mem_ack;
  logic        mem_err;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic        pc_inc;
  logic        pc_branch;
  logic        illegal_op;

  modport master (
    input  instr_valid, instr, alu_zero, mem_ack,
    output instr_ready, rf_raddr1, rf_raddr2, alu_op, alu_src, alu_funct,
           alu_shamt, alu_immd, mem_req, mem_we, mem_err, rf_we, rf_waddr,
           pc_inc, pc_branch, illegal_op
  );

  modport slave (
    output instr_valid, instr, alu_zero, mem_ack,
    input  instr_ready, rf_raddr1, rf_raddr2, alu_op, alu_src, alu_funct,
           alu_shamt, alu_immd, mem_req, mem_we, mem_err, rf_we, rf_waddr,
           pc_inc, pc_branch, illegal_op
  );
endinterface

// File: rtl/mips_ctrl_fsm.sv
// Multi-cycle MIPS control FSM (R, ADDI, LW, SW, BEQ) with bounded memory wait.
// Define ILLEGAL_TRAP_EN to lock up in TRAP on an illegal opcode instead of retiring it as a NOP.
module mips_ctrl_fsm #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic           clk,
  input  logic           rst,
  mips_ctrl_fsm_if.master bus
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_BEQ  = 6'h04;

  typedef enum logic [2:0] {
    S_FETCH, S_DEC, S_EXE, S_MEM, S_MERR, S_WB, S_TRAP
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   ir_q, ir_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    alu_op_q, alu_op_d;
  logic          alu_src_q, alu_src_d;
  logic [5:0]    alu_funct_q, alu_funct_d;
  logic [4:0]    alu_shamt_q, alu_shamt_d;
  logic [31:0]   alu_immd_q, alu_immd_d;
  logic          illegal_op_q, illegal_op_d;

  logic [5:0] opcode;
  logic       is_r, is_addi, is_lw, is_sw, is_beq, is_legal;
  logic [4:0] waddr;
  logic       timeout;

  assign opcode   = ir_q[31:26];
  assign is_r     = (opcode == OP_R);
  assign is_addi  = (opcode == OP_ADDI);
  assign is_lw    = (opcode == OP_LW);
  assign is_sw    = (opcode == OP_SW);
  assign is_beq   = (opcode == OP_BEQ);
  assign is_legal = is_r | is_addi | is_lw | is_sw | is_beq;
  assign waddr    = is_r ? ir_q[15:11] : ir_q[20:16];
  // cnt_q holds the number of MEM cycles already spent without an ack
  assign timeout  = (cnt_q == CW'(MEM_TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_FETCH;
      ir_q         <= '0;
      cnt_q        <= '0;
      alu_op_q     <= '0;
      alu_src_q    <= 1'b0;
      alu_funct_q  <= '0;
      alu_shamt_q  <= '0;
      alu_immd_q   <= '0;
      illegal_op_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ir_q         <= ir_d;
      cnt_q        <= cnt_d;
      alu_op_q     <= alu_op_d;
      alu_src_q    <= alu_src_d;
      alu_funct_q  <= alu_funct_d;
      alu_shamt_q  <= alu_shamt_d;
      alu_immd_q   <= alu_immd_d;
      illegal_op_q <= illegal_op_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    ir_d         = ir_q;
    cnt_d        = '0;
    alu_op_d     = alu_op_q;
    alu_src_d    = alu_src_q;
    alu_funct_d  = alu_funct_q;
    alu_shamt_d  = alu_shamt_q;
    alu_immd_d   = alu_immd_q;
    illegal_op_d = illegal_op_q;
    unique case (state_q)
      S_FETCH: begin
        if (bus.instr_valid) begin
          ir_d    = bus.instr;
          state_d = S_DEC;
        end
      end
      S_DEC: begin
        alu_funct_d = ir_q[5:0];
        alu_shamt_d = ir_q[10:6];
        alu_immd_d  = {{16{ir_q[15]}}, ir_q[15:0]};
        alu_op_d    = is_r ? 2'b10 : (is_beq ? 2'b01 : 2'b00);
        alu_src_d   = is_addi | is_lw | is_sw;
        if (is_legal) begin
          state_d = S_EXE;
        end else begin
`ifdef ILLEGAL_TRAP_EN
          illegal_op_d = 1'b1;
          state_d      = S_TRAP;
`else
          state_d = S_FETCH;
`endif
        end
      end
      S_EXE: begin
        if (is_lw | is_sw) state_d = S_MEM;
        else if (is_beq)   state_d = S_FETCH;
        else               state_d = S_WB;
      end
      S_MEM: begin
        // an ack on the last allowed cycle still completes the access
        if (bus.mem_ack)  state_d = is_lw ? S_WB : S_FETCH;
        else if (timeout) state_d = S_MERR;
        else              cnt_d   = cnt_q + 1'b1;
      end
      S_MERR:  state_d = S_FETCH;
      S_WB:    state_d = S_FETCH;
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
  end

  logic instr_ready, mem_req, mem_we, mem_err, rf_we, pc_inc, pc_branch;

  always_comb begin
    instr_ready = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_err     = 1'b0;
    rf_we       = 1'b0;
    pc_inc      = 1'b0;
    pc_branch   = 1'b0;
    unique case (state_q)
      S_FETCH: instr_ready = 1'b1;
      S_DEC: begin
`ifndef ILLEGAL_TRAP_EN
        pc_inc = ~is_legal;
`endif
      end
      S_EXE: begin
        if (is_beq) begin
          pc_branch = bus.alu_zero;
          pc_inc    = ~bus.alu_zero;
        end
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = is_sw;
        pc_inc  = is_sw & bus.mem_ack;
      end
      S_MERR: begin
        mem_err = 1'b1;
        pc_inc  = 1'b1;
      end
      S_WB: begin
        rf_we  = (waddr != 5'd0);
        pc_inc = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.instr_ready = instr_ready;
  assign bus.rf_raddr1   = ir_q[25:21];
  assign bus.rf_raddr2   = ir_q[20:16];
  assign bus.alu_op      = alu_op_q;
  assign bus.alu_src     = alu_src_q;
  assign bus.alu_funct   = alu_funct_q;
  assign bus.alu_shamt   = alu_shamt_q;
  assign bus.alu_immd    = alu_immd_q;
  assign bus.mem_req     = mem_req;
  assign bus.mem_we      = mem_we;
  assign bus.mem_err     = mem_err;
  assign bus.rf_we       = rf_we;
  assign bus.rf_waddr    = waddr;
  assign bus.pc_inc      = pc_inc;
  assign bus.pc_branch   = pc_branch;
  assign bus.illegal_op  = illegal_op_q;

endmodule

// File: tb/tb_mips_ctrl_fsm.sv
// Randomized bench for mips_ctrl_fsm: each instruction's full output timeline is
// built from its class, memory-ack cycle and zero flag, then checked every cycle.
module tb_mips_ctrl_fsm;

  localparam int MT = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mips_ctrl_fsm_if bus ();

  mips_ctrl_fsm #(.MEM_TIMEOUT(MT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // expectations for the current cycle
  bit          chk_on = 1'b0;
  int          cur_cycle;
  logic        e_ready, e_pc_inc, e_pc_branch, e_rf_we, e_mem_req, e_mem_we, e_mem_err;
  bit          e_alu_chk, e_raddr_chk, e_waddr_chk;
  logic [1:0]  e_alu_op;
  logic        e_alu_src;
  logic [5:0]  e_funct;
  logic [4:0]  e_shamt, e_raddr1, e_raddr2, e_waddr;
  logic [31:0] e_immd;

  // observations of the current instruction, for literal pins
  int          cap_lat, cap_memreq, cap_memerr, cap_rfwe, cap_pcinc, cap_pcbr;
  logic [31:0] cap_immd;
  logic [5:0]  cap_funct;
  logic [4:0]  cap_waddr;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d, t=%0t)", nm, act, exp, cur_cycle, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      cmp("instr_ready", 32'(bus.instr_ready), 32'(e_ready));
      cmp("pc_inc", 32'(bus.pc_inc), 32'(e_pc_inc));
      cmp("pc_branch", 32'(bus.pc_branch), 32'(e_pc_branch));
      cmp("rf_we", 32'(bus.rf_we), 32'(e_rf_we));
      cmp("mem_req", 32'(bus.mem_req), 32'(e_mem_req));
      cmp("mem_err", 32'(bus.mem_err), 32'(e_mem_err));
      cmp("illegal_op", 32'(bus.illegal_op), 32'd0);
      if (e_mem_req) cmp("mem_we", 32'(bus.mem_we), 32'(e_mem_we));
      if (e_alu_chk) begin
        cmp("alu_op", 32'(bus.alu_op), 32'(e_alu_op));
        cmp("alu_src", 32'(bus.alu_src), 32'(e_alu_src));
        cmp("alu_funct", 32'(bus.alu_funct), 32'(e_funct));
        cmp("alu_shamt", 32'(bus.alu_shamt), 32'(e_shamt));
        cmp("alu_immd", bus.alu_immd, e_immd);
      end
      if (e_raddr_chk) begin
        cmp("rf_raddr1", 32'(bus.rf_raddr1), 32'(e_raddr1));
        cmp("rf_raddr2", 32'(bus.rf_raddr2), 32'(e_raddr2));
      end
      if (e_waddr_chk) cmp("rf_waddr", 32'(bus.rf_waddr), 32'(e_waddr));
      if (cur_cycle > 0 && bus.instr_ready && cap_lat < 0) cap_lat = cur_cycle;
      if (bus.mem_req)   cap_memreq++;
      if (bus.mem_err)   cap_memerr++;
      if (bus.pc_inc)    cap_pcinc++;
      if (bus.pc_branch) cap_pcbr++;
      if (bus.rf_we) begin
        cap_rfwe++;
        cap_waddr = bus.rf_waddr;
      end
      if (cur_cycle == 2) begin
        cap_immd  = bus.alu_immd;
        cap_funct = bus.alu_funct;
      end
    end
  end

  // Plays one instruction from its accept cycle (cycle 0). ack_n = MEM cycle carrying
  // mem_ack (1-based), 0 = never. idle adds one FETCH cycle with instr_valid low.
  task automatic run_instr(input logic [31:0] ins, input int ack_n, input bit zero, input bit idle);
    int   cls;
    int   len;
    int   nmem;
    bit   in_mem;
    logic [5:0] op;
    logic [4:0] wa;
    op = ins[31:26];
    case (op)
      6'h00:   cls = 0;
      6'h08:   cls = 1;
      6'h23:   cls = 2;
      6'h2B:   cls = 3;
      6'h04:   cls = 4;
      default: cls = 5;
    endcase
    wa   = (cls == 0) ? ins[15:11] : ins[20:16];
    nmem = (ack_n > 0) ? ack_n : MT;
    case (cls)
      0, 1:    len = 4;
      2:       len = (ack_n > 0) ? 4 + ack_n : 4 + MT;
      3:       len = (ack_n > 0) ? 3 + ack_n : 4 + MT;
      4:       len = 3;
      default: len = 2;
    endcase
    cap_lat = -1; cap_memreq = 0; cap_memerr = 0; cap_rfwe = 0; cap_pcinc = 0; cap_pcbr = 0;
    for (int c = 0; c <= len; c++) begin
      if (c == len && !idle) break;
      cur_cycle = c;
      in_mem = (cls == 2 || cls == 3) && c >= 3 && c <= 2 + nmem;
      bus.instr_valid = (c == 0) ? 1'b1 : ((c == len) ? 1'b0 : 1'($urandom_range(0, 1)));
      bus.instr       = (c == 0) ? ins : $urandom();
      bus.alu_zero    = (c == 2) ? zero : 1'($urandom_range(0, 1));
      bus.mem_ack     = in_mem ? (ack_n > 0 && c == 2 + ack_n) : 1'($urandom_range(0, 1));
      e_ready = (c == 0 || c == len);
      e_pc_inc = 0; e_pc_branch = 0; e_rf_we = 0; e_mem_req = 0; e_mem_we = 0; e_mem_err = 0;
      e_waddr_chk = 0;
      e_waddr     = wa;
      e_raddr_chk = (c >= 1);
      e_raddr1    = ins[25:21];
      e_raddr2    = ins[20:16];
      e_alu_chk   = (cls != 5) && (c >= 2);
      e_alu_op    = (cls == 0) ? 2'd2 : ((cls == 4) ? 2'd1 : 2'd0);
      e_alu_src   = (cls == 1 || cls == 2 || cls == 3);
      e_funct     = ins[5:0];
      e_shamt     = ins[10:6];
      e_immd      = 32'($signed(ins[15:0]));
      if (cls == 0 || cls == 1) begin
        if (c == 3) begin e_rf_we = (wa != 0); e_pc_inc = 1; e_waddr_chk = 1; end
      end else if (cls == 4) begin
        if (c == 2) begin e_pc_branch = zero; e_pc_inc = !zero; end
      end else if (cls == 2 || cls == 3) begin
        if (in_mem) begin e_mem_req = 1; e_mem_we = (cls == 3); end
        if (ack_n > 0 && cls == 3 && c == 2 + ack_n) e_pc_inc = 1;
        if (ack_n > 0 && cls == 2 && c == 3 + ack_n) begin
          e_rf_we = (wa != 0); e_pc_inc = 1; e_waddr_chk = 1;
        end
        if (ack_n == 0 && c == 3 + MT) begin e_mem_err = 1; e_pc_inc = 1; end
      end else begin
        if (c == 1) e_pc_inc = 1;
      end
      chk_on = 1'b1;
      @(posedge clk); #1;
    end
    chk_on = 1'b0;
  endtask

  task automatic random_phase();
    int          k;
    int          ack;
    logic [31:0] ins;
    logic [5:0]  op;
    for (int i = 0; i < 300; i++) begin
      k   = $urandom_range(0, 9);
      ins = $urandom();
      case (k)
        0, 1:    op = 6'h00;
        2:       op = 6'h08;
        3, 4:    op = 6'h23;
        5, 6:    op = 6'h2B;
        7, 8:    op = 6'h04;
        default: begin
`ifdef ILLEGAL_TRAP_EN
          op = 6'h00;
`else
          do op = 6'($urandom_range(0, 63));
          while (op inside {6'h00, 6'h08, 6'h23, 6'h2B, 6'h04});
`endif
        end
      endcase
      ins[31:26] = op;
      if ($urandom_range(0, 5) == 0) ins[15:11] = 5'd0;
      if ($urandom_range(0, 5) == 0) ins[20:16] = 5'd0;
      ack = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, MT);
      run_instr(ins, ack, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic reset_mid_lw();
    cur_cycle = -1;
    bus.instr_valid = 1'b1; bus.instr = 32'h8C45FFFC; bus.mem_ack = 1'b0;
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    cmp("mid_mem_req", 32'(bus.mem_req), 32'd1);
    #1 rst = 1'b1;
    #1;
    cmp("rst_mem_req", 32'(bus.mem_req), 32'd0);
    cmp("rst_rf_we", 32'(bus.rf_we), 32'd0);
    cmp("rst_pc_inc", 32'(bus.pc_inc), 32'd0);
    cmp("rst_ready", 32'(bus.instr_ready), 32'd1);
    bus.mem_ack = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.mem_ack = 1'b0;
    repeat (3) begin
      @(negedge clk);
      cmp("post_rst_ready", 32'(bus.instr_ready), 32'd1);
      cmp("post_rst_rf_we", 32'(bus.rf_we), 32'd0);
      cmp("post_rst_pc_inc", 32'(bus.pc_inc), 32'd0);
      cmp("post_rst_mem_req", 32'(bus.mem_req), 32'd0);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    cur_cycle = -1;
    rst = 1'b1;
    bus.instr_valid = 1'b0; bus.instr = '0; bus.alu_zero = 1'b0; bus.mem_ack = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    cmp("reset_ready", 32'(bus.instr_ready), 32'd1);
    cmp("reset_pulses", {25'd0, bus.pc_inc, bus.pc_branch, bus.rf_we, bus.mem_req,
                         bus.mem_we, bus.mem_err, bus.illegal_op}, 32'd0);
    cmp("reset_alu", {bus.alu_op, bus.alu_src, bus.alu_funct, bus.alu_shamt, 13'd0}, 32'd0);
    cmp("reset_immd", bus.alu_immd, 32'd0);
    cmp("reset_addr", {17'd0, bus.rf_raddr1, bus.rf_raddr2, bus.rf_waddr}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    run_instr(32'h00221820, 0, 1'b0, 1'b1);
    cmp("add_latency", cap_lat, 4);
    cmp("add_funct", 32'(cap_funct), 32'h20);
    cmp("add_waddr", 32'(cap_waddr), 32'd3);

    run_instr(32'h8C45FFFC, 3, 1'b0, 1'b1);
    cmp("lw_immd", cap_immd, 32'hFFFFFFFC);
    cmp("lw_waddr", 32'(cap_waddr), 32'd5);
    cmp("lw_latency", cap_lat, 7);

    run_instr(32'h10220003, 0, 1'b1, 1'b1);
    cmp("beq_taken_branch", cap_pcbr, 1);
    cmp("beq_taken_inc", cap_pcinc, 0);
    run_instr(32'h10220003, 0, 1'b0, 1'b1);
    cmp("beq_not_taken_inc", cap_pcinc, 1);
    cmp("beq_latency", cap_lat, 3);

    run_instr(32'hAC450008, 0, 1'b0, 1'b1);
    cmp("sw_to_memreq_cycles", cap_memreq, 16);
    cmp("sw_to_memerr", cap_memerr, 1);
    cmp("sw_to_rf_we", cap_rfwe, 0);
    cmp("sw_to_latency", cap_lat, 20);

    run_instr(32'h00000000, 0, 1'b0, 1'b1);
    cmp("nop_rf_we", cap_rfwe, 0);
    cmp("nop_pc_inc", cap_pcinc, 1);

`ifndef ILLEGAL_TRAP_EN
    run_instr(32'hFC000000, 0, 1'b0, 1'b1);
    cmp("illegal_latency", cap_lat, 2);
    cmp("illegal_pc_inc", cap_pcinc, 1);
`endif

    reset_mid_lw();
    random_phase();

`ifdef ILLEGAL_TRAP_EN
    cur_cycle = -1;
    bus.instr_valid = 1'b1; bus.instr = 32'hFC000000;
    @(posedge clk); #1;
    @(negedge clk);
    repeat (5) begin
      @(negedge clk);
      cmp("trap_ready", 32'(bus.instr_ready), 32'd0);
      cmp("trap_illegal_op", 32'(bus.illegal_op), 32'd1);
      cmp("trap_pc_inc", 32'(bus.pc_inc), 32'd0);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    cmp("trap_cleared", 32'(bus.illegal_op), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
